fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the byte-addressed, 256-byte instruction memory.
- The memory has a registered read: address presented in cycle N, word available in cycle N+1.
- Owns the PC, issues word reads, and tracks the single in-flight read.
- Buffers returned words in a 2-entry skid FIFO and delivers them to decode over a valid/ready handshake; supports redirect (branch/jump) and halt/drain.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_skid_buf.sv | 51 +++++
 rtl/fetch_ctrl.sv | 116 +++++++++++
 tb/tb_fetch_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam int          PC_INC           = 4;
  localparam int          FIFO_DEPTH       = 2;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry skid FIFO of {pc, instr} between the memory return path and decode.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic [XLEN-1:0] push_instr,
  input  logic            pop,
  input  logic            flush,
  output logic            head_valid,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_instr,
  output logic [1:0]      count
);

  logic [FIFO_DEPTH-1:0][XLEN-1:0] pc_q, instr_q;
  logic                            wr_ptr, rd_ptr;
  logic                            do_pop;

  assign head_valid = (count != 2'd0);
  assign do_pop     = pop & head_valid;
  assign head_pc    = pc_q[rd_ptr];
  assign head_instr = instr_q[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        pc_q[wr_ptr]    <= push_pc;
        instr_q[wr_ptr] <= push_instr;
        wr_ptr          <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC, single in-flight read tracking, FSM and decode handshake.
// Optional FETCH_ALIGN_CHK_EN adds a sticky fetch_err for bad redirect targets.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEFAULT_RESET_PC),
  parameter int              MEM_BYTES = 256
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            busy
`ifdef FETCH_ALIGN_CHK_EN
  ,
  output logic            fetch_err
`endif
);

  localparam logic [XLEN-1:0] PC_MASK    = XLEN'(MEM_BYTES - 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = PC_MASK & ~(XLEN'(3));

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, inflight_pc_q;
  logic            inflight_q;
  logic            redir, pop, issue, push;
  logic [1:0]      fifo_count;
  logic [2:0]      pending;

  fetch_skid_buf #(.XLEN(XLEN)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_pc    (inflight_pc_q),
    .push_instr (imem_rdata),
    .pop        (pop),
    .flush      (redir),
    .head_valid (instr_valid),
    .head_pc    (instr_pc),
    .head_instr (instr),
    .count      (fifo_count)
  );

`ifdef FETCH_ALIGN_CHK_EN
  logic bad_target;
  assign bad_target = redir && ((redirect_pc[1:0] != 2'd0) || (redirect_pc >= XLEN'(MEM_BYTES)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             fetch_err <= 1'b0;
    else if (bad_target) fetch_err <= 1'b1;
  end
`endif

  assign busy = (state_q == FETCH) || (state_q == DRAIN);

  // Words already owed to the buffer, net of the head leaving this cycle.
  assign pending = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);

  always_comb begin
    state_d = state_q;
    redir   = redirect_valid && (state_q != IDLE);
    pop     = instr_valid && instr_ready;
    issue   = (state_q == FETCH) && !halt && !redir && (pending < 3'd2);
    push    = inflight_q && !redir;

    unique case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  if (halt) state_d = DRAIN;
      DRAIN:  if (!inflight_q) state_d = HALTED;
      HALTED: if (!halt) state_d = FETCH;
      default: state_d = IDLE;
    endcase

    if (redir) begin
      if (state_q == DRAIN || state_q == HALTED) state_d = HALTED;
      else                                       state_d = halt ? DRAIN : FETCH;
    end
`ifdef FETCH_ALIGN_CHK_EN
    if (bad_target || fetch_err) state_d = HALTED;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      imem_addr     <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (redir) begin
      // The in-flight word belongs to the abandoned stream and is dropped.
      pc_q       <= redirect_pc & ALIGN_MASK;
      inflight_q <= 1'b0;
    end else begin
      if (issue) begin
        imem_addr     <= pc_q;
        inflight_pc_q <= pc_q;
        pc_q          <= (pc_q + XLEN'(PC_INC)) & PC_MASK;
      end
      inflight_q <= issue;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: vector table, directed corner cases, random run vs stream model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;
  logic        busy;
`ifdef FETCH_ALIGN_CHK_EN
  logic        fetch_err;
`endif

  always #5 clk = ~clk;

  fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0), .MEM_BYTES(256)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .busy           (busy)
`ifdef FETCH_ALIGN_CHK_EN
    ,
    .fetch_err      (fetch_err)
`endif
  );

  // Memory whose output follows the registered address, giving the one-cycle read.
  logic [31:0] mem [64];
  assign imem_rdata = mem[imem_addr[7:2]];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return mem[a[7:2]];
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Stream model: decode must see consecutive PCs (mod 256), restarting at each redirect target.
  logic        mon_en = 1'b0;
  logic [31:0] m_pc = 32'h0;
  int          pops = 0;
  logic        stab_pend = 1'b0;
  logic [31:0] stab_pc = 32'h0, stab_instr = 32'h0;

  always @(negedge clk) begin
    if (!mon_en || rst) begin
      m_pc      = 32'h0;
      stab_pend = 1'b0;
    end else begin
      if (stab_pend) begin
        chk("hold_valid", 32'(instr_valid), 32'd1);
        chk("hold_pc", instr_pc, stab_pc);
        chk("hold_instr", instr, stab_instr);
      end
      stab_pend  = instr_valid && !instr_ready && !redirect_valid;
      stab_pc    = instr_pc;
      stab_instr = instr;
      if (instr_valid && instr_ready) begin
        chk("stream_pc", instr_pc, m_pc);
        chk("stream_instr", instr, word_at(m_pc));
        m_pc = (m_pc + 32'd4) & 32'hFF;
        pops++;
      end
      if (redirect_valid) m_pc = redirect_pc & 32'hFC;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    step(1);
    redirect_valid = 1'b0;
  endtask

  task automatic expect_next(input logic [31:0] e, input string nm);
    int w;
    w = 0;
    while (!instr_valid && w < 20) begin
      step(1);
      w++;
    end
    if (!instr_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: instr_valid never rose, expected pc %h", nm, e);
    end else begin
      chk(nm, instr_pc, e);
      chk({nm, "_instr"}, instr, word_at(e));
    end
    step(1);
  endtask

  typedef struct {
    logic        ready;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_busy;
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mk(input logic r, input logic [31:0] a, input logic v, input logic [31:0] p);
    vec_t t;
    t.ready = r; t.exp_addr = a; t.exp_valid = v; t.exp_pc = p; t.exp_busy = 1'b1;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h;
    int          p0;
    logic [31:0] wrap_seq [4];

    mem[0] = 32'h01022083;
    for (int i = 1; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i * 4);

    // Reset release then 5 cycles of backpressure mid-stream.
    vt[0] = mk(1'b1, 32'd0,  1'b0, 32'd0);
    vt[1] = mk(1'b1, 32'd0,  1'b0, 32'd0);
    vt[2] = mk(1'b1, 32'd4,  1'b1, 32'd0);
    vt[3] = mk(1'b1, 32'd8,  1'b1, 32'd4);
    vt[4] = mk(1'b1, 32'd12, 1'b1, 32'd8);
    vt[5] = mk(1'b1, 32'd16, 1'b1, 32'd12);
    for (int i = 6; i <= 10; i++) vt[i] = mk(1'b0, 32'd16, 1'b1, 32'd12);
    vt[11] = mk(1'b1, 32'd20, 1'b1, 32'd16);
    vt[12] = mk(1'b1, 32'd24, 1'b1, 32'd20);
    vt[13] = mk(1'b1, 32'd28, 1'b1, 32'd24);

    step(2);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 14; i++) begin
      instr_ready = vt[i].ready;
      step(1);
      chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].exp_addr);
      chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vt[i].exp_valid));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].exp_busy));
      if (vt[i].exp_valid) begin
        chk($sformatf("vec%0d_pc", i), instr_pc, vt[i].exp_pc);
        chk($sformatf("vec%0d_instr", i), instr, word_at(vt[i].exp_pc));
      end
    end

    // Redirect while a read is in flight.
    instr_ready = 1'b0;
    redirect_to(32'h40);
    chk("redir_flush", 32'(instr_valid), 32'd0);
    instr_ready = 1'b1;
    expect_next(32'h40, "redir_a0");
    expect_next(32'h44, "redir_a1");
    expect_next(32'h48, "redir_a2");

    // Redirect with the buffer full.
    instr_ready = 1'b0;
    step(3);
    chk("full_valid", 32'(instr_valid), 32'd1);
    redirect_to(32'h80);
    chk("full_flush", 32'(instr_valid), 32'd0);
    instr_ready = 1'b1;
    expect_next(32'h80, "redir_b0");
    expect_next(32'h84, "redir_b1");

    // Wrap-around, with the redirect cycle itself popping the head.
    redirect_to(32'hF8);
    wrap_seq[0] = 32'hF8; wrap_seq[1] = 32'hFC; wrap_seq[2] = 32'h00; wrap_seq[3] = 32'h04;
    for (int i = 0; i < 4; i++) expect_next(wrap_seq[i], $sformatf("wrap%0d", i));

    // Halt mid-stream: head and in-flight word both drain, then idle.
    step(3);
    h    = m_pc;
    p0   = pops;
    halt = 1'b1;
    step(1);
    chk("halt_drain_busy", 32'(busy), 32'd1);
    step(3);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_valid", 32'(instr_valid), 32'd0);
    chk("halt_pops", 32'(pops - p0), 32'd2);
    chk("halt_addr", imem_addr, (h + 32'd4) & 32'hFF);
    halt = 1'b0;
    expect_next((h + 32'd8) & 32'hFF, "halt_resume");

    // Reset mid-operation.
    step(2);
    #1;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_pc", instr_pc, 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_addr", imem_addr, 32'd0);
    step(2);
    rst    = 1'b0;
    mon_en = 1'b1;
    expect_next(32'h0, "post_rst0");
    expect_next(32'h4, "post_rst1");

    // Random traffic against the stream model.
    for (int c = 0; c < 1500; c++) begin
      instr_ready    = ($urandom % 4) != 0;
      if ($urandom % 32 == 0) halt = ~halt;
      redirect_valid = ($urandom % 40) == 0;
`ifdef FETCH_ALIGN_CHK_EN
      redirect_pc    = $urandom & 32'hFC;
`else
      redirect_pc    = $urandom;
`endif
      step(1);
    end
    redirect_valid = 1'b0;
    halt           = 1'b0;
    instr_ready    = 1'b1;
    expect_next(m_pc, "rand_live");

`ifdef FETCH_ALIGN_CHK_EN
    redirect_to(32'h42);
    chk("err_set", 32'(fetch_err), 32'd1);
    chk("err_valid", 32'(instr_valid), 32'd0);
    step(3);
    chk("err_busy", 32'(busy), 32'd0);
    redirect_to(32'h40);
    step(5);
    chk("err_sticky", 32'(fetch_err), 32'd1);
    chk("err_halted", 32'(busy), 32'd0);
    chk("err_novalid", 32'(instr_valid), 32'd0);
    mon_en = 1'b0;
    rst    = 1'b1;
    step(1);
    chk("err_rst", 32'(fetch_err), 32'd0);
    rst = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
